// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle sequencing controller for the MIPS_32 datapath.
// The controller sequences each instruction over 3 to 5 cycles. One shared memory
// port uses a mem_ready handshake. The controller also counts retired instructions
// and traps on unknown opcodes.
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   run_i                 fetch enable (sampled in FETCH only)
//   opcode_i, zero_i      instr[31:26] from IR, ALU zero flag
//   mem_ready_i           memory completed the current access this cycle
//   pc_write_o .. pc_src_o  datapath controls (Moore decode of state, gated by
//                         run/mem_ready in FETCH and by zero in BRANCH)
//   state_o               current state encoding
//   illegal_o             sticky trap flag
//   retired_o             retired-instruction counter (wraps)
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_src_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;
  logic               retire;

  // Next-state and retirement decode
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:    if (run_i && mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode_i)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      // Opcode is held in the IR, so it is still valid here
      S_MEM_ADDR: state_d = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State, counter and sticky trap registers; reset aborts with no retirement
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Datapath control decode
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 2'd0;
    pc_src_o     = 2'd0;
    unique case (state_q)
      S_FETCH: begin
        if (run_i) begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          // PC <- PC+4 only when the instruction word actually arrives
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
      end
      S_DECODE:   alu_src_b_o = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd2;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_WB_I:     reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd1;
        pc_src_o    = 2'd1;
        pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed scenarios plus a randomized
// instruction stream, checked cycle by cycle against a per-instruction script
// model built from the instruction-class sequencing rules.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, run_i, zero_i, mem_ready_i;
  logic [5:0]  opcode_i;

  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  logic [14:0] ctl4;
  logic [3:0]  state4, retired4;
  logic        illegal4;

  int checks = 0;
  int failures = 0;
  int unsigned cnt = 0;   // model retirement count
  int unsigned ncyc = 0;  // cycles stepped
  logic exp_ill = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write), .ir_write_o(ir_write), .iord_o(iord),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .reg_write_o(reg_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
    .state_o(state), .illegal_o(illegal), .retired_o(retired)
  );

  // Narrow-counter instance for wrap behaviour, driven identically
  mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(ctl4[14]), .ir_write_o(ctl4[13]), .iord_o(ctl4[12]),
    .mem_read_o(ctl4[11]), .mem_write_o(ctl4[10]), .reg_write_o(ctl4[9]),
    .reg_dst_o(ctl4[8]), .mem_to_reg_o(ctl4[7]), .alu_src_a_o(ctl4[6]),
    .alu_src_b_o(ctl4[5:4]), .alu_op_o(ctl4[3:2]), .pc_src_o(ctl4[1:0]),
    .state_o(state4), .illegal_o(illegal4), .retired_o(retired4)
  );

  logic [14:0] obs_ctl;
  assign obs_ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  // Field order: pcw irw iord mrd mwr rw rdst m2r asa asb aop psrc
  function automatic logic [14:0] mk(input logic pcw, irw, io, mrd, mwr, rw,
                                     rdst, m2r, asa, input logic [1:0] asb,
                                     aop, psrc);
    return {pcw, irw, io, mrd, mwr, rw, rdst, m2r, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance past posedge
  task automatic cyc(input logic run, input logic rdy, input logic [14:0] ectl,
                     input logic [3:0] est, input bit ret);
    run_i = run;
    mem_ready_i = rdy;
    @(negedge clk);
    chk("state", 32'(state), 32'(est));
    chk("ctl", 32'(obs_ctl), 32'(ectl));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    chk("retired", retired, cnt);
    chk("retired4", 32'(retired4), cnt % 16);
    chk("ctl4", {illegal4, state4, ctl4}, {illegal, state, obs_ctl});
    chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    @(posedge clk);
    #1;
    ncyc++;
    if (ret) cnt++;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    run_i = 1'($urandom);
    mem_ready_i = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst_i = 1'b0;
    cnt = 0;
    exp_ill = 1'b0;
  endtask

  function automatic logic rb(input bit rnd);
    return rnd ? 1'($urandom) : 1'b1;
  endfunction

  // Script of one instruction: fetch waits, decode, then class-specific steps.
  // rnd randomizes run/mem_ready where they must be ignored.
  task automatic do_instr(input logic [5:0] op, input logic z, input int wf,
                          input int wm, input bit rnd);
    logic [14:0] f;
    logic tk;
    opcode_i = op;
    zero_i = z;
    f = mk(0,0,0,1,0,0,0,0,0,2'd1,2'd0,2'd0);
    for (int i = 0; i < wf; i++) cyc(1, 0, f, 4'd0, 0);
    cyc(1, 1, f | mk(1,1,0,0,0,0,0,0,0,2'd0,2'd0,2'd0), 4'd0, 0);
    cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0), 4'd1, 0);
    case (op)
      6'h23: begin
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), 4'd2, 0);
        for (int i = 0; i < wm; i++)
          cyc(rb(rnd), 0, mk(0,0,1,1,0,0,0,0,0,2'd0,2'd0,2'd0), 4'd3, 0);
        cyc(rb(rnd), 1, mk(0,0,1,1,0,0,0,0,0,2'd0,2'd0,2'd0), 4'd3, 0);
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0), 4'd4, 1);
      end
      6'h2B: begin
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), 4'd2, 0);
        for (int i = 0; i < wm; i++)
          cyc(rb(rnd), 0, mk(0,0,1,0,1,0,0,0,0,2'd0,2'd0,2'd0), 4'd5, 0);
        cyc(rb(rnd), 1, mk(0,0,1,0,1,0,0,0,0,2'd0,2'd0,2'd0), 4'd5, 1);
      end
      6'h00: begin
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0), 4'd6, 0);
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,1,1,0,0,2'd0,2'd0,2'd0), 4'd7, 1);
      end
      6'h08: begin
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), 4'd8, 0);
        cyc(rb(rnd), rb(rnd), mk(0,0,0,0,0,1,0,0,0,2'd0,2'd0,2'd0), 4'd9, 1);
      end
      6'h04, 6'h05: begin
        tk = (op == 6'h04) ? z : ~z;
        cyc(rb(rnd), rb(rnd), mk(tk,0,0,0,0,0,0,0,1,2'd0,2'd1,2'd1), 4'd10, 1);
      end
      6'h02: cyc(rb(rnd), rb(rnd), mk(1,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd2), 4'd11, 1);
      default: begin
        exp_ill = 1'b1;
        for (int i = 0; i < 10; i++) cyc(rb(rnd), rb(rnd), 15'd0, 4'd12, 0);
      end
    endcase
  endtask

  initial begin
    logic [5:0] ops [7];
    int base;
    ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00; ops[3] = 6'h08;
    ops[4] = 6'h04; ops[5] = 6'h05; ops[6] = 6'h02;
    opcode_i = 6'h00;
    zero_i = 1'b0;

    // Reset and run gating
    do_reset(2);
    for (int i = 0; i < 3; i++) cyc(0, 1'($urandom), 15'd0, 4'd0, 0);

    // lw with two wait cycles in MEM_RD
    do_instr(6'h23, 1'b0, 0, 2, 0);

    // Branch taken (beq, zero=1) and not taken (bne, zero=1)
    do_reset(1);
    do_instr(6'h04, 1'b1, 0, 0, 0);
    do_instr(6'h05, 1'b1, 0, 0, 0);

    // Back-to-back mix: R, addi, sw, j -> 15 cycles
    do_reset(1);
    base = int'(ncyc);
    do_instr(6'h00, 1'b0, 0, 0, 0);
    do_instr(6'h08, 1'b0, 0, 0, 0);
    do_instr(6'h2B, 1'b0, 0, 0, 0);
    do_instr(6'h02, 1'b0, 0, 0, 0);
    chk("mix_cycles", ncyc - 32'(base), 32'd15);

    // Illegal opcode traps until reset
    do_instr(6'h3F, 1'b0, 1, 0, 1);
    do_reset(1);
    cyc(0, 1, 15'd0, 4'd0, 0);

    // Randomized instruction stream with idle and wait cycles
    for (int n = 0; n < 60; n++) begin
      int idle = int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) cyc(0, 1'($urandom), 15'd0, 4'd0, 0);
      do_instr(ops[$urandom_range(0, 6)], 1'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1);
    end

    // Reset during MEM_WR with mem_ready=1: aborted, not retired
    opcode_i = 6'h2B;
    cyc(1, 1, mk(1,1,0,1,0,0,0,0,0,2'd1,2'd0,2'd0), 4'd0, 0);
    cyc(1, 1, mk(0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0), 4'd1, 0);
    cyc(1, 1, mk(0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), 4'd2, 0);
    rst_i = 1'b1;
    cyc(1, 1, mk(0,0,1,0,1,0,0,0,0,2'd0,2'd0,2'd0), 4'd5, 0);
    rst_i = 1'b0;
    cnt = 0;
    cyc(0, 1, 15'd0, 4'd0, 0);

    // 16 retirements wrap the 4-bit counter
    for (int i = 0; i < 16; i++) do_instr(6'h02, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("wrap4", 32'(retired4), 32'd0);
    chk("count32", retired, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
